// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Optional read-bypass logic elsewhere is enabled with the RF_BYPASS_EN macro.
package rf_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    import rf_ctrl_pkg::*;

    logic rr_last_r;

    // Grant selection from current requests and last winner
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_last_r == REQ_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the last granted requester; reset favours ALU on first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_r <= REQ_LSU;
        end else if (grant[1]) begin
            rr_last_r <= REQ_LSU;
        end else if (grant[0]) begin
            rr_last_r <= REQ_ALU;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write port owner: zero-clear sweep after reset, then ALU/LSU writeback arbitration.
// Define RF_BYPASS_EN to add rs1/rs2 forwarding around the registered write.
module regfile_wb_ctrl #(
    parameter int XLEN = rf_ctrl_pkg::XLEN,
    parameter int AW   = rf_ctrl_pkg::AW,
    parameter int NREG = rf_ctrl_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rdsel,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rdsel,
    input  logic [XLEN-1:0] lsu_data,
`ifdef RF_BYPASS_EN
    input  logic [AW-1:0]   rs1sel,
    input  logic [AW-1:0]   rs2sel,
    input  logic [XLEN-1:0] rs1_raw,
    input  logic [XLEN-1:0] rs2_raw,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
`endif
    output logic            enrd,
    output logic [AW-1:0]   rdsel,
    output logic [XLEN-1:0] rd,
    output logic            init_done
);
    import rf_ctrl_pkg::*;

    state_e          state_r;
    logic [AW-1:0]   cnt_r;
    logic [1:0]      valid_s;
    logic [1:0]      grant_s;
    logic            acc_s;
    logic [AW-1:0]   sel_s;
    logic [XLEN-1:0] data_s;

    assign valid_s = (state_r == RUN) ? {lsu_valid, alu_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid_s),
        .grant (grant_s)
    );

    assign alu_ready = grant_s[REQ_ALU];
    assign lsu_ready = grant_s[REQ_LSU];

    // Payload of the accepted requester
    always_comb begin
        acc_s = grant_s[REQ_ALU] | grant_s[REQ_LSU];
        if (grant_s[REQ_LSU]) begin
            sel_s  = lsu_rdsel;
            data_s = lsu_data;
        end else begin
            sel_s  = alu_rdsel;
            data_s = alu_data;
        end
    end

    // Sweep sequencer and registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= INIT;
            cnt_r     <= {AW{1'b0}};
            enrd      <= 1'b0;
            rdsel     <= {AW{1'b0}};
            rd        <= {XLEN{1'b0}};
            init_done <= 1'b0;
        end else begin
            // init_done lags RUN by one cycle so the last sweep write has landed
            init_done <= (state_r == RUN);
            case (state_r)
                INIT: begin
                    enrd  <= 1'b1;
                    rdsel <= cnt_r;
                    rd    <= {XLEN{1'b0}};
                    cnt_r <= cnt_r + AW'(1);
                    if (cnt_r == AW'(NREG - 1)) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= INIT;
                    end
                end
                RUN: begin
                    if (acc_s) begin
                        // x0 is hardwired zero: handshake completes but no write
                        enrd  <= (sel_s != {AW{1'b0}});
                        rdsel <= sel_s;
                        rd    <= data_s;
                    end else begin
                        enrd <= 1'b0;
                    end
                end
                default: begin
                    state_r <= INIT;
                    cnt_r   <= {AW{1'b0}};
                    enrd    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_BYPASS_EN
    assign rs1 = (enrd && (rdsel == rs1sel) && (rs1sel != {AW{1'b0}})) ? rd : rs1_raw;
    assign rs2 = (enrd && (rdsel == rs2sel) && (rs2sel != {AW{1'b0}})) ? rd : rs2_raw;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: behavioural model plus expected-write scoreboard queue.
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rdsel, lsu_rdsel;
    logic [31:0] alu_data, lsu_data;
    logic        enrd;
    logic [4:0]  rdsel;
    logic [31:0] rd;
    logic        init_done;
    logic [4:0]  rs1sel, rs2sel;
    logic [31:0] rs1_raw, rs2_raw, rs1, rs2;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic        m_run, m_rr, m_enrd, m_done;
    logic [4:0]  m_cnt, m_rdsel;
    logic [31:0] m_rd;
    logic        m_ga, m_gl;
    logic [36:0] exp_q[$];

    regfile_wb_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rdsel (alu_rdsel),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rdsel (lsu_rdsel),
        .lsu_data  (lsu_data),
`ifdef RF_BYPASS_EN
        .rs1sel    (rs1sel),
        .rs2sel    (rs2sel),
        .rs1_raw   (rs1_raw),
        .rs2_raw   (rs2_raw),
        .rs1       (rs1),
        .rs2       (rs2),
`endif
        .enrd      (enrd),
        .rdsel     (rdsel),
        .rd        (rd),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic run_cycle();
        logic [36:0] e;
        logic [4:0]  sel;
        logic [31:0] dat;
        #1;
        m_ga = 1'b0;
        m_gl = 1'b0;
        if (rst_n && m_run) begin
            m_ga = alu_valid && (!lsu_valid || m_rr);
            m_gl = lsu_valid && (!alu_valid || !m_rr);
        end
        check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, m_ga});
        check_eq("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_gl});
        if (!rst_n) begin
            m_run = 1'b0; m_cnt = 5'd0; m_rr = 1'b1;
            m_enrd = 1'b0; m_rdsel = 5'd0; m_rd = 32'd0; m_done = 1'b0;
            exp_q.delete();
        end else if (!m_run) begin
            m_enrd = 1'b1; m_rdsel = m_cnt; m_rd = 32'd0; m_done = 1'b0;
            exp_q.push_back({m_cnt, 32'd0});
            if (m_cnt == 5'd31) m_run = 1'b1;
            m_cnt = m_cnt + 5'd1;
        end else begin
            m_done = 1'b1;
            if (m_ga || m_gl) begin
                sel = m_gl ? lsu_rdsel : alu_rdsel;
                dat = m_gl ? lsu_data : alu_data;
                m_rr = m_gl;
                m_rdsel = sel;
                m_rd = dat;
                m_enrd = (sel != 5'd0);
                if (sel != 5'd0) exp_q.push_back({sel, dat});
            end else begin
                m_enrd = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("enrd", {31'd0, enrd}, {31'd0, m_enrd});
        check_eq("init_done", {31'd0, init_done}, {31'd0, m_done});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("wr_rdsel", {27'd0, rdsel}, {27'd0, e[36:32]});
            check_eq("wr_rd", rd, e[31:0]);
        end else begin
            check_eq("hold_rdsel", {27'd0, rdsel}, {27'd0, m_rdsel});
            check_eq("hold_rd", rd, m_rd);
        end
`ifdef RF_BYPASS_EN
        check_eq("rs1", rs1, (m_enrd && m_rdsel == rs1sel && rs1sel != 5'd0) ? m_rd : rs1_raw);
        check_eq("rs2", rs2, (m_enrd && m_rdsel == rs2sel && rs2sel != 5'd0) ? m_rd : rs2_raw);
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rdsel = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rdsel = 5'd0; lsu_data = 32'd0;
        rs1sel = 5'd7; rs1_raw = 32'd0; rs2sel = 5'd0; rs2_raw = 32'hCAFE0000;
        m_run = 1'b0; m_cnt = 5'd0; m_rr = 1'b1; m_enrd = 1'b0;
        m_rdsel = 5'd0; m_rd = 32'd0; m_done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) run_cycle();

        // sweep with both requesters pushing: readys must stay low
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rdsel = 5'd3; alu_data = 32'h11111111;
        lsu_valid = 1'b1; lsu_rdsel = 5'd4; lsu_data = 32'h22222222;
        for (int i = 0; i < 32; i++) run_cycle();
        idle(2);

        // ALU only
        alu_valid = 1'b1; alu_rdsel = 5'd5; alu_data = 32'hDEADBEEF;
        run_cycle();
        idle(1);

        // LSU write to x0 is swallowed
        lsu_valid = 1'b1; lsu_rdsel = 5'd0; lsu_data = 32'h00001234;
        run_cycle();
        idle(1);

        // both valid, alternating grants
        alu_valid = 1'b1; alu_rdsel = 5'd1; alu_data = 32'h0000AAAA;
        lsu_valid = 1'b1; lsu_rdsel = 5'd2; lsu_data = 32'h0000BBBB;
        for (int i = 0; i < 4; i++) run_cycle();
        idle(1);

        // bypass target write to x7
        rs1sel = 5'd7; rs1_raw = 32'd0;
        alu_valid = 1'b1; alu_rdsel = 5'd7; alu_data = 32'hA5A5A5A5;
        run_cycle();
        idle(1);

        // random traffic honouring hold-until-ready
        alu_valid = 1'b0; lsu_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!alu_valid) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rdsel = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!lsu_valid) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rdsel = 5'($urandom);
                lsu_data  = $urandom;
            end
            rs1sel = 5'($urandom); rs2sel = 5'($urandom);
            rs1_raw = $urandom; rs2_raw = $urandom;
            run_cycle();
            if (m_ga) alu_valid = 1'b0;
            if (m_gl) lsu_valid = 1'b0;
        end
        idle(1);

        // reset mid-sweep restarts from index 0
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(10);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Owns the single write port of the 32x32 integer register file.
- After reset, sequences a zero-clear sweep of every register, because the file array itself has no reset.
- Then shares the write port between two writeback requesters, ALU (req 0) and LSU (req 1), using round-robin arbitration with valid/ready handshakes.
- Drives the regfile's enrd/rdsel/rd inputs from registers.

Parameters:
- XLEN, 32, data width of register contents.
- AW, 5, register index width.
- NREG, 32, number of registers swept at init (= 2**AW).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rdsel  in  AW  ALU destination index.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request accepted this cycle.
- lsu_rdsel  in  AW  LSU destination index.
- lsu_data  in  XLEN  load data.
- enrd  out  1  regfile write enable (registered).
- rdsel  out  AW  regfile write index (registered).
- rd  out  XLEN  regfile write data (registered).
- init_done  out  1  high once the clear sweep is complete.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=INIT, sweep counter=0, rr_last=1 (so ALU wins the first tie).
  - Outputs: enrd=0, rdsel=0, rd=0, init_done=0.
  - alu_ready and lsu_ready are 0 combinationally whenever state!=RUN.
- INIT state:
  - Each cycle registers enrd=1, rdsel=counter, rd=0, then increments the counter.
  - After the cycle that registers rdsel=NREG-1, moves to RUN.
  - That write lands on the edge ending the following cycle, so init_done rises on the cycle after the last sweep write is presented (NREG+1 cycles after reset release).
  - Sweep includes x0.
  - Reset mid-sweep restarts at index 0.
- RUN state, arbitration (combinational ready):
  - Only ALU valid -> alu_ready=1. Only LSU valid -> lsu_ready=1.
  - Both valid -> grant the requester not equal to rr_last. rr_last updates to the granted index on every grant.
  - At most one ready per cycle. Ready is never asserted without the matching valid.
- Write issue:
  - The accepted request is registered into enrd/rdsel/rd on the next edge, a 1-cycle latency from handshake to port.
  - Regfile array update occurs one edge later.
  - Throughput is one write per cycle, no bubbles.
  - No accept in a cycle -> enrd=0 next cycle; rdsel/rd hold their previous values.
- x0 rule: an accepted request with rdsel=0 completes its handshake normally, but registers enrd=0.
- Requester contract: valid plus payload must hold until ready. The block does not check this.
- No stall path: RUN never returns to INIT except through reset.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined, adds these ports:
  - rs1sel, rs2sel  in  AW  read selects.
  - rs1_raw, rs2_raw  in  XLEN  regfile read data.
  - rs1, rs2  out  XLEN  forwarded read data.
- Forwarding rule, combinational: rsX = (enrd && rdsel==rsXsel && rsXsel!=0) ? rd : rsX_raw.
  - Hides the one-cycle window between registered write and array update.
  - During INIT, rs1/rs2 still forward sweep zeros.
- When undefined, these ports do not exist and no bypass muxes are built.

Decomposition:
- Package rf_ctrl_pkg:
  - XLEN/AW/NREG constants.
  - state enum {INIT, RUN}.
  - requester index constants REQ_ALU=0, REQ_LSU=1.
- One sub-module, rr_arb2: two-input round-robin arbiter holding rr_last, with inputs valid[1:0] and outputs grant[1:0].

Test Plan:
- Release rst_n, no requests -> enrd=1 for 32 consecutive cycles, rdsel 0..31, rd=0; init_done=1 on cycle 33; all readys 0 until RUN.
- RUN, ALU only: rdsel=5, data=0xDEADBEEF -> alu_ready same cycle; next cycle enrd=1, rdsel=5, rd=0xDEADBEEF.
- Both valid for 4 cycles, ALU rd=1 and LSU rd=2 (each re-presenting after grant) -> grants ALU, LSU, ALU, LSU; enrd stream rdsel 1, 2, 1, 2.
- LSU writes rdsel=0, data=0x1234 -> lsu_ready=1, next cycle enrd=0.
- Assert rst_n=0 at sweep index 10, release -> sweep restarts at rdsel=0 and runs a full 32 writes.
- RF_BYPASS_EN: ALU writes x7=0xA5A5A5A5 with rs1sel=7, rs1_raw=0 in the enrd cycle -> rs1=0xA5A5A5A5. Then rs2sel=0 with enrd/rdsel=0 -> rs2=rs2_raw.
